req_latch_arb: RTL and testbench
================================

# req_latch_arb

Request capture and arbitration stage sitting directly upstream of the 8-to-3 encoder. It detects rising edges on eight asynchronous-to-protocol request lines and holds them as pending. One pending request at a time is presented as a one-hot `grant` vector with an `en` strobe; these drive the encoder's `i0..i7`/`en` inputs. Each grant is held until the downstream consumer acknowledges it.

## Interface
Parameters:
- `CNT_W`, 8, width of the dropped-request counter (saturating).

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  8  request lines, bit k = source k; rising edge = new request.
- `ack`  input  1  consumer has taken the current grant; only meaningful while `en`=1.
- `grant`  output  8  one-hot selected source while `en`=1, all-zero otherwise.
- `en`  output  1  grant valid; feeds encoder enable.
- `pending`  output  8  registered pending-request vector (observability).
- `drop_cnt`  output  CNT_W  count of edges arriving on an already-pending bit; saturates at all-ones.

## Operation
- Edge detect: `req_q` registers `req`; `edge = req & ~req_q`. `req_q` resets to 8'hFF, so lines held high through reset create no request.
- Pending update per edge: `pending_next = (pending & ~clr) | edge`; set wins over clear on the same bit.
- `clr` is the one-hot `grant` when `ack`=1 and `en`=1, else 0.
- Drop: for each bit with `edge`=1 and `pending`=1 (before clear), increment `drop_cnt` by 1. Multiple simultaneous drops count as one per cycle (saturating).
- FSM states, all transitions registered:
  - IDLE: `en`=0. Goes to GRANT when `pending`!=0; `grant` is loaded from the picker.
  - GRANT: `en`=1, `grant` stable. On `ack`: clear the bit, go to GAP. `ack` while not in GRANT is ignored.
  - GAP: `en`=0 for exactly one cycle, so the encoder sees distinct events. Then go to GRANT if `pending`!=0 (new pick), else IDLE.
- Picker (default): fixed priority, bit 7 highest, bit 0 lowest.
- `grant` never changes while `en`=1, even if a higher-priority request arrives.

## Timing
- Reset values: `grant`=0, `en`=0, `pending`=0, `drop_cnt`=0, state IDLE, `req_q`=8'hFF, rotate pointer=7.
- `req` rises and is sampled at edge t → `pending` bit set after edge t.
- In IDLE, `en`/`grant` are asserted after edge t+1. Request-to-grant latency is 2 clocks.
- `ack` sampled high at edge a → after edge a: `en`=0, `grant`=0, bit cleared.
- Earliest next grant is after edge a+1. Back-to-back grants are therefore 2 clocks apart minimum.
- `rst` asserted mid-grant: everything returns to reset values after that edge. The in-flight grant is lost and not replayed.
- Edge on the granted bit in the same cycle as its `ack`: the bit stays pending and is granted again after GAP. This does not count as a drop.

## Configuration
- `ROUND_ROBIN_EN` defined:
  - The picker searches descending from `ptr`, wrapping 0→7.
  - After each acknowledged grant of bit k, `ptr` = (k−1) mod 8.
  - `ptr` resets to 7.
- Not defined: fixed priority (bit 7 highest); no pointer register exists.

## Structure
- Package `req_arb_pkg`:
  - `N_REQ`=8.
  - State enum `arb_state_t` {IDLE, GRANT, GAP}.
  - Reset constant `REQ_Q_RST`=8'hFF.
- Sub-module `prio_pick`: combinational, inputs `vec[7:0]` and `start[2:0]`, output one-hot `sel[7:0]`. Searches descending from `start` with wrap. Fixed-priority mode ties `start`=7.

## Test plan
- Reset with `req`=8'hFF held high, then release → no `pending`, `en`=0 indefinitely, `drop_cnt`=0.
- Single pulse on `req[5]` at edge t → `pending`=8'h20 after t, `grant`=8'h20 with `en`=1 after t+1. `ack` at edge a → `pending`=0, `en`=0 after a.
- `req` rises 8'h00→8'h81 in one cycle, fixed priority → grants 8'h80 then 8'h01, with one `en`=0 GAP cycle between them. With `ROUND_ROBIN_EN`, after grant 7 then 0, a new 8'h81 grants 8'h80 first (ptr wrapped to 7).
- While bit 3 is pending, pulse `req[3]` twice more → `drop_cnt`=2, still only one grant for bit 3. With `CNT_W`=2, six drops → `drop_cnt`=3 (saturated).
- New edge on the granted bit 2 in the same cycle as `ack` → bit 2 remains pending and is re-granted after GAP; `drop_cnt` unchanged.
- `rst` pulsed while `en`=1 on bit 4 with bit 1 pending → after the edge all outputs are zero; no grant follows unless new edges arrive.

Source files
------------

// File: rtl/req_arb_pkg.sv
// req_arb_pkg: shared constants, FSM state type and one-hot index helper for req_latch_arb
package req_arb_pkg;
  localparam int N_REQ = 8;
  localparam logic [N_REQ-1:0] REQ_Q_RST = 8'hFF;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;
  function automatic logic [2:0] oh2idx(input logic [N_REQ-1:0] oh);
    oh2idx = '0;
    for (int i = 0; i < N_REQ; i++) oh2idx = oh[i] ? 3'(i) : oh2idx;
  endfunction
endpackage

// File: rtl/prio_pick.sv
// prio_pick: one-hot select of the first set bit in vec searching downward from start with wrap
module prio_pick
  import req_arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  input  logic [2:0]       start,
  output logic [N_REQ-1:0] sel
);
  always_comb begin
    sel = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      sel = vec[start - 3'(i)] ? N_REQ'(1) << (start - 3'(i)) : sel;
  end
endmodule

// File: rtl/req_latch_arb.sv
// req_latch_arb: latches request rising edges and grants one pending source at a time until ack (ROUND_ROBIN_EN selects rotating priority)
module req_latch_arb
  import req_arb_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             ack,
  output logic [N_REQ-1:0] grant,
  output logic             en,
  output logic [N_REQ-1:0] pending,
  output logic [CNT_W-1:0] drop_cnt
);
  arb_state_t state, state_n;
  logic [N_REQ-1:0] req_q, rise, clr, pick, grant_n;
  logic [2:0] start;
  logic drop;
  assign rise = req & ~req_q;
  assign en = state == GRANT;
  assign clr = (en && ack) ? grant : '0;
  assign drop = |(rise & pending & ~clr);
`ifdef ROUND_ROBIN_EN
  logic [2:0] ptr;
  assign start = ptr;
  always_ff @(posedge clk)
    if (rst) ptr <= 3'd7;
    else if (en && ack) ptr <= oh2idx(grant) - 3'd1;
`else
  assign start = 3'd7;
`endif
  prio_pick u_pick (.vec(pending), .start(start), .sel(pick));
  always_comb begin
    state_n = state;
    grant_n = grant;
    case (state)
      IDLE, GAP: begin
        state_n = |pending ? GRANT : IDLE;
        grant_n = |pending ? pick : '0;
      end
      GRANT: begin
        state_n = ack ? GAP : GRANT;
        grant_n = ack ? '0 : grant;
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      pending <= '0;
      drop_cnt <= '0;
      req_q <= REQ_Q_RST;
    end else begin
      state <= state_n;
      grant <= grant_n;
      pending <= (pending & ~clr) | rise;
      drop_cnt <= (drop && !(&drop_cnt)) ? drop_cnt + CNT_W'(1) : drop_cnt;
      req_q <= req;
    end
endmodule

// File: tb/tb_req_latch_arb.sv
// tb_req_latch_arb: directed and randomized checks of req_latch_arb against a behavioural model
module tb_req_latch_arb;
  localparam int CW = 8;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst, ack, en;
  logic [7:0] req, grant, pending;
  logic [CW-1:0] drop_cnt;
  int total = 0;
  int bad = 0;
  bit m_pend[8];
  bit m_reqq[8];
  int m_gnt, m_ptr, m_drop;

  req_latch_arb #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .grant(grant), .en(en), .pending(pending), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pick();
    int s;
`ifdef ROUND_ROBIN_EN
    s = m_ptr;
`else
    s = 7;
`endif
    for (int i = 0; i < 8; i++)
      if (m_pend[(s - i + 8) % 8]) return (s - i + 8) % 8;
    return -1;
  endfunction

  function automatic logic [7:0] model_pend();
    logic [7:0] v = '0;
    for (int k = 0; k < 8; k++) v[k] = m_pend[k];
    return v;
  endfunction

  task automatic step(input logic [7:0] r, input logic a, input logic rs);
    bit e[8];
    int c;
    bit d;
    req = r;
    ack = a;
    rst = rs;
    @(posedge clk);
    if (rs) begin
      for (int k = 0; k < 8; k++) begin
        m_pend[k] = 0;
        m_reqq[k] = 1;
      end
      m_gnt = -1;
      m_ptr = 7;
      m_drop = 0;
    end else begin
      c = (m_gnt >= 0 && a) ? m_gnt : -1;
      d = 0;
      for (int k = 0; k < 8; k++) begin
        e[k] = r[k] && !m_reqq[k];
        if (e[k] && m_pend[k] && k != c) d = 1;
      end
      if (d && m_drop < MAXC) m_drop++;
      if (m_gnt >= 0) begin
        if (a) begin
          m_gnt = -1;
          m_ptr = (c + 7) % 8;
        end
      end else m_gnt = model_pick();
      for (int k = 0; k < 8; k++) begin
        m_pend[k] = (m_pend[k] && k != c) || e[k];
        m_reqq[k] = r[k];
      end
    end
    #1;
    check("en", 32'(en), 32'(m_gnt >= 0));
    check("grant", 32'(grant), m_gnt >= 0 ? 32'(1) << m_gnt : 32'd0);
    check("pending", 32'(pending), 32'(model_pend()));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  initial begin
    logic [7:0] r;
    r = 8'hFF;
    req = 8'hFF;
    ack = 1'b0;
    rst = 1'b1;
    repeat (3) step(8'hFF, 1'b0, 1'b1);
    repeat (6) step(8'hFF, 1'b0, 1'b0);
    check("held_high_no_en", 32'(en), 32'd0);
    check("held_high_no_pend", 32'(pending), 32'd0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h20, 1'b0, 1'b0);
    check("pulse5_pend", 32'(pending), 32'h20);
    check("pulse5_no_en_yet", 32'(en), 32'd0);
    step(8'h00, 1'b0, 1'b0);
    check("pulse5_grant", 32'(grant), 32'h20);
    step(8'h00, 1'b1, 1'b0);
    check("pulse5_acked", 32'(pending), 32'h00);
    step(8'h00, 1'b0, 1'b0);
    step(8'h81, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    check("pair_first", 32'(grant), 32'h80);
    step(8'h00, 1'b1, 1'b0);
    check("pair_gap", 32'(en), 32'd0);
    step(8'h00, 1'b0, 1'b0);
    check("pair_second", 32'(grant), 32'h01);
    step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h81, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    check("pair_again_first", 32'(grant), 32'h80);
    step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h80, 1'b0, 1'b0);
    step(8'h88, 1'b0, 1'b0);
    step(8'h80, 1'b0, 1'b0);
    step(8'h88, 1'b0, 1'b0);
    step(8'h80, 1'b0, 1'b0);
    step(8'h88, 1'b0, 1'b0);
    check("drop_two", 32'(drop_cnt), 32'd2);
    check("drop_hold_grant", 32'(grant), 32'h80);
    step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    check("drop_bit3_grant", 32'(grant), 32'h08);
    step(8'h00, 1'b1, 1'b0);
    repeat (3) step(8'h00, 1'b0, 1'b0);
    check("drop_single_grant", 32'(en), 32'd0);
    step(8'h04, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    check("regrant_first", 32'(grant), 32'h04);
    step(8'h04, 1'b1, 1'b0);
    check("regrant_kept", 32'(pending), 32'h04);
    check("regrant_no_drop", 32'(drop_cnt), 32'd2);
    step(8'h00, 1'b0, 1'b0);
    check("regrant_again", 32'(grant), 32'h04);
    step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h12, 1'b0, 1'b0);
    step(8'h12, 1'b0, 1'b0);
    check("rst_pre_grant", 32'(grant), 32'h10);
    step(8'h12, 1'b0, 1'b1);
    check("rst_mid_en", 32'(en), 32'd0);
    check("rst_mid_pend", 32'(pending), 32'd0);
    repeat (4) step(8'h12, 1'b0, 1'b0);
    check("rst_no_replay", 32'(en), 32'd0);
    r = 8'h12;
    for (int n = 0; n < 2000; n++) begin
      r = r ^ (($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
      step(r, 1'($urandom_range(0, 1)), $urandom_range(0, 199) == 0);
    end
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0);
    for (int n = 0; n < 600; n++) step((n % 2 == 0) ? 8'h01 : 8'h00, 1'b0, 1'b0);
    check("drop_saturated", 32'(drop_cnt), 32'(MAXC));
    step(8'h01, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h01, 1'b0, 1'b0);
    check("drop_stays_sat", 32'(drop_cnt), 32'(MAXC));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
